// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 4-word lines and a
// two-state LOOKUP/REFILL controller that fetches whole lines from memory.
module icache #(
    parameter int NUM_LINES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fetch_valid,
    input  logic [31:0]  pc_in,
    input  logic         flush,
    output logic [31:0]  instruction_out,
    output logic         instruction_valid,
    output logic         stall,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_valid,
    input  logic [127:0] mem_rdata,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [127:0]         r_data [NUM_LINES];
    logic [31:2]          r_pc;
    logic                 r_flushed;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic [31:0]          w_hit_word;
    logic [IDX_W-1:0]     w_fill_idx;
    logic [31:0]          w_fill_word;
    logic                 w_unused_bits;

    assign w_idx         = pc_in[4 +: IDX_W];
    assign w_tag         = pc_in[31 -: TAG_W];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_word    = r_data[w_idx][{pc_in[3:2], 5'd0} +: 32];
    assign w_fill_idx    = r_pc[4 +: IDX_W];
    // The requested word bypasses the array so it is available on the fill edge.
    assign w_fill_word   = mem_rdata[{r_pc[3:2], 5'd0} +: 32];
    assign w_unused_bits = ^pc_in[1:0];

    // Stall: any refill in flight, a flush, or a missing fetch; never during reset.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = 1'b0;
        end else if (r_state == REFILL) begin
            stall = 1'b1;
        end else if (flush) begin
            stall = 1'b1;
        end else if (fetch_valid && !w_hit) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Controller: lookup/refill sequencing, valid bits, outputs and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= LOOKUP;
            r_valid           <= '0;
            r_pc              <= 30'd0;
            r_flushed         <= 1'b0;
            instruction_out   <= 32'd0;
            instruction_valid <= 1'b0;
            mem_req           <= 1'b0;
            mem_addr          <= 32'd0;
            hit_count         <= 16'd0;
            miss_count        <= 16'd0;
        end else begin
            instruction_valid <= 1'b0;
            case (r_state)
                LOOKUP: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (fetch_valid && w_hit) begin
                        instruction_out   <= w_hit_word;
                        instruction_valid <= 1'b1;
                        hit_count         <= hit_count + 16'd1;
                    end else if (fetch_valid) begin
                        r_pc       <= pc_in[31:2];
                        r_flushed  <= 1'b0;
                        miss_count <= miss_count + 16'd1;
                        mem_req    <= 1'b1;
                        mem_addr   <= {pc_in[31:4], 4'b0000};
                        r_state    <= REFILL;
                    end else begin
                        r_state <= LOOKUP;
                    end
                end
                REFILL: begin
                    if (mem_valid) begin
                        // A flush seen at any point of this refill keeps the line invalid.
                        if (flush) begin
                            r_valid <= '0;
                        end else begin
                            r_valid[w_fill_idx] <= !r_flushed;
                        end
                        instruction_out   <= w_fill_word;
                        instruction_valid <= 1'b1;
                        mem_req           <= 1'b0;
                        r_state           <= LOOKUP;
                    end else if (flush) begin
                        r_valid   <= '0;
                        r_flushed <= 1'b1;
                    end else begin
                        r_state <= REFILL;
                    end
                end
                default: begin
                    r_state <= LOOKUP;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Line storage: data and tags need no reset because valid bits gate every use.
    always_ff @(posedge clk) begin
        if ((r_state == REFILL) && mem_valid) begin
            r_data[w_fill_idx] <= mem_rdata;
            r_tag[w_fill_idx]  <= r_pc[31 -: TAG_W];
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: hits, misses, conflicts, flushes,
// reset during refill and hit-counter wrap.
module tb_icache;

    logic         clk;
    logic         reset;
    logic         fetch_valid;
    logic [31:0]  pc_in;
    logic         flush;
    logic [31:0]  instruction_out;
    logic         instruction_valid;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_valid;
    logic [127:0] mem_rdata;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] LINE0 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] LINE4 = 128'h44440003_44440002_44440001_44440000;

    icache #(.NUM_LINES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .pc_in             (pc_in),
        .flush             (flush),
        .instruction_out   (instruction_out),
        .instruction_valid (instruction_valid),
        .stall             (stall),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_valid         (mem_valid),
        .mem_rdata         (mem_rdata),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        fetch_valid = 1'b1;
        pc_in       = 32'h0000_0040;
        flush       = 1'b0;
        mem_valid   = 1'b0;
        mem_rdata   = 128'd0;
        #1 reset = 1'b0;
        #1;
        chk("rst_iv",    {31'd0, instruction_valid}, 32'd0);
        chk("rst_iout",  instruction_out, 32'd0);
        chk("rst_mreq",  {31'd0, mem_req}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_hits",  {16'd0, hit_count}, 32'd0);
        chk("rst_miss",  {16'd0, miss_count}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        step();
        step();
        reset = 1'b1;

        // Cold miss on 0x0 with memory answering in the third refill cycle.
        pc_in = 32'h0000_0000;
        #1;
        chk("miss0_stall", {31'd0, stall}, 32'd1);
        step();
        chk("miss0_mreq",  {31'd0, mem_req}, 32'd1);
        chk("miss0_maddr", mem_addr, 32'd0);
        chk("miss0_cnt",   {16'd0, miss_count}, 32'd1);
        step();
        step();
        chk("refill_wait_iv", {31'd0, instruction_valid}, 32'd0);
        chk("refill_wait_stall", {31'd0, stall}, 32'd1);
        mem_valid = 1'b1;
        mem_rdata = LINE0;
        step();
        mem_valid = 1'b0;
        chk("fill0_iv",   {31'd0, instruction_valid}, 32'd1);
        chk("fill0_iout", instruction_out, 32'h0000_0000);
        chk("fill0_mreq", {31'd0, mem_req}, 32'd0);
        chk("fill0_miss", {16'd0, miss_count}, 32'd1);
        fetch_valid = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);

        // Hits on the resident line.
        fetch_valid = 1'b1;
        pc_in = 32'h0000_0008;
        #1;
        chk("hit8_stall", {31'd0, stall}, 32'd0);
        step();
        chk("hit8_iout", instruction_out, 32'h2222_2222);
        chk("hit8_iv",   {31'd0, instruction_valid}, 32'd1);
        chk("hit8_cnt",  {16'd0, hit_count}, 32'd1);
        chk("hit8_mreq", {31'd0, mem_req}, 32'd0);
        pc_in = 32'h0000_000C;
        step();
        chk("hitC_iout", instruction_out, 32'h3333_3333);
        chk("hitC_cnt",  {16'd0, hit_count}, 32'd2);
        fetch_valid = 1'b0;
        step();
        chk("idle_iv",   {31'd0, instruction_valid}, 32'd0);
        chk("idle_hold", instruction_out, 32'h3333_3333);

        // Conflict on the same index evicts line 0x0.
        fetch_valid = 1'b1;
        pc_in = 32'h0000_0044;
        #1;
        chk("miss40_stall", {31'd0, stall}, 32'd1);
        step();
        chk("miss40_maddr", mem_addr, 32'h0000_0040);
        chk("miss40_cnt",   {16'd0, miss_count}, 32'd2);
        mem_valid = 1'b1;
        mem_rdata = LINE4;
        step();
        mem_valid = 1'b0;
        chk("fill40_iout", instruction_out, 32'h4444_0001);
        chk("fill40_iv",   {31'd0, instruction_valid}, 32'd1);
        pc_in = 32'h0000_0004;
        #1;
        chk("evict_stall", {31'd0, stall}, 32'd1);
        step();
        chk("evict_cnt",   {16'd0, miss_count}, 32'd3);
        chk("evict_maddr", mem_addr, 32'h0000_0000);
        mem_valid = 1'b1;
        mem_rdata = LINE0;
        step();
        chk("fill0b_iout", instruction_out, 32'h1111_1111);

        // mem_valid while idle in LOOKUP must be ignored.
        fetch_valid = 1'b0;
        mem_rdata = LINE4;
        step();
        mem_valid = 1'b0;
        chk("stray_iv",   {31'd0, instruction_valid}, 32'd0);
        chk("stray_mreq", {31'd0, mem_req}, 32'd0);

        // Flush beats a simultaneous would-be hit.
        fetch_valid = 1'b1;
        pc_in = 32'h0000_0008;
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd1);
        step();
        flush = 1'b0;
        chk("flush_iv",   {31'd0, instruction_valid}, 32'd0);
        chk("flush_hits", {16'd0, hit_count}, 32'd2);
        chk("flush_miss", {16'd0, miss_count}, 32'd3);
        #1;
        chk("postflush_stall", {31'd0, stall}, 32'd1);
        step();
        chk("postflush_mreq", {31'd0, mem_req}, 32'd1);
        chk("postflush_miss", {16'd0, miss_count}, 32'd4);

        // Flush during refill: instruction still delivered, line stays invalid.
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("rflush_mreq", {31'd0, mem_req}, 32'd1);
        mem_valid = 1'b1;
        mem_rdata = LINE0;
        step();
        mem_valid = 1'b0;
        chk("rflush_iv",   {31'd0, instruction_valid}, 32'd1);
        chk("rflush_iout", instruction_out, 32'h2222_2222);
        #1;
        chk("rflush_inval_stall", {31'd0, stall}, 32'd1);
        step();
        chk("rflush_miss", {16'd0, miss_count}, 32'd5);

        // Reset in the middle of a refill aborts it.
        reset = 1'b0;
        #1;
        chk("rrst_mreq",  {31'd0, mem_req}, 32'd0);
        chk("rrst_miss",  {16'd0, miss_count}, 32'd0);
        chk("rrst_hits",  {16'd0, hit_count}, 32'd0);
        chk("rrst_stall", {31'd0, stall}, 32'd0);
        step();
        reset = 1'b1;
        fetch_valid = 1'b0;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        chk("rrst_iv",   {31'd0, instruction_valid}, 32'd0);
        chk("rrst_mreq2", {31'd0, mem_req}, 32'd0);
        fetch_valid = 1'b1;
        pc_in = 32'h0000_0008;
        #1;
        chk("rrst_refetch_stall", {31'd0, stall}, 32'd1);
        step();
        chk("rrst_refetch_miss", {16'd0, miss_count}, 32'd1);
        mem_valid = 1'b1;
        mem_rdata = LINE0;
        step();
        mem_valid = 1'b0;
        chk("rrst_fill_iout", instruction_out, 32'h2222_2222);

        // 65536 consecutive hits wrap hit_count back to zero.
        repeat (65535) step();
        chk("wrap_ffff", {16'd0, hit_count}, 32'h0000_FFFF);
        step();
        chk("wrap_zero", {16'd0, hit_count}, 32'd0);
        chk("wrap_miss", {16'd0, miss_count}, 32'd1);
        chk("wrap_iv",   {31'd0, instruction_valid}, 32'd1);
        chk("wrap_iout", instruction_out, 32'h2222_2222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The module SHALL have parameter NUM_LINES, default 4 (power of two, >=2), giving the number of direct-mapped lines of 4 x 32-bit words each.
REQ-002 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The module SHALL have port fetch_valid, input, 1: fetch request for pc_in.
REQ-005 The module SHALL have port pc_in, input, 32: fetch address; bits [1:0] ignored.
REQ-006 The module SHALL have port flush, input, 1: invalidate all lines.
REQ-007 The module SHALL have port instruction_out, output, 32: fetched instruction word.
REQ-008 The module SHALL have port instruction_valid, output, 1: instruction_out valid this cycle.
REQ-009 The module SHALL have port stall, output, 1: fetch not accepted, and the requester holds pc_in/fetch_valid.
REQ-010 The module SHALL have port mem_req, output, 1: line refill request to main memory.
REQ-011 The module SHALL have port mem_addr, output, 32: 16-byte-aligned refill address.
REQ-012 The module SHALL have port mem_valid, input, 1: mem_rdata valid, one-cycle pulse.
REQ-013 The module SHALL have port mem_rdata, input, 128: refill line, with word k at bits [32k+31:32k].
REQ-014 The module SHALL have ports hit_count and miss_count, output, 16 each: performance counters.

Function
REQ-015 Address split SHALL be: word = pc[3:2]; index = pc[3+log2(NUM_LINES):4]; tag = all higher bits.
REQ-016 The FSM SHALL have two states: LOOKUP and REFILL.
REQ-017 In LOOKUP, when fetch_valid=1 and flush=0 and the line is valid with a matching tag (hit), the next edge SHALL register the selected word on instruction_out with instruction_valid=1 and increment hit_count; hit latency is 1 cycle.
REQ-018 In LOOKUP, when fetch_valid=1 and flush=0 and there is no hit (miss), stall SHALL be 1 combinationally, and the next edge SHALL latch pc_in, increment miss_count, and enter REFILL.
REQ-019 In REFILL, mem_req SHALL be 1, mem_addr SHALL be {latched pc[31:4], 4'b0} held stable, and stall SHALL be 1.
REQ-020 In REFILL, the edge sampling mem_valid=1 SHALL write the data, tag and valid bit for the line, register the requested word on instruction_out with instruction_valid=1, and return to LOOKUP.
REQ-021 Refill data for the requested word SHALL come from mem_rdata directly and not be re-read from the array.
REQ-022 stall SHALL be 0 whenever fetch_valid=0 in LOOKUP with flush=0.
REQ-023 instruction_valid SHALL be 0 in every cycle not produced by REQ-017 or REQ-020; instruction_out SHALL hold its last value otherwise.
REQ-024 In LOOKUP, flush=1 SHALL clear all valid bits at the edge, take priority over a simultaneous fetch (no lookup, no counter change), and force stall=1 that cycle.
REQ-025 Flush during REFILL SHALL clear all valid bits; the outstanding refill SHALL still deliver its instruction, but that line's valid bit SHALL remain 0.
REQ-026 mem_valid SHALL be ignored in LOOKUP.
REQ-027 hit_count and miss_count SHALL wrap from 0xFFFF to 0x0000.
REQ-028 A conflicting tag on refill SHALL overwrite the resident line without write-back, since the cache is read-only.

Reset
REQ-029 reset=0 SHALL immediately set state=LOOKUP, clear all valid bits, and drive instruction_valid=0, instruction_out=0, mem_req=0, mem_addr=0, hit_count=0 and miss_count=0, independent of clk.
REQ-030 While reset=0, stall SHALL be 0.
REQ-031 Reset asserted during REFILL SHALL abort the refill; a later mem_valid SHALL be ignored.
REQ-032 Data array contents need not be reset.

Verification
REQ-033 After reset, fetch pc=0x00000000 -> stall=1, mem_req=1, mem_addr=0x0; mem_valid after 3 cycles with mem_rdata=0x33333333_22222222_11111111_00000000 -> next edge instruction_out=0x00000000, instruction_valid=1, miss_count=1.
REQ-034 Then fetch pc=0x00000008 -> stall=0, mem_req stays 0, and one cycle later instruction_out=0x22222222, instruction_valid=1, hit_count=1.
REQ-035 With NUM_LINES=4, fetch 0x00000040 (same index) -> miss and refill; then fetch 0x00000000 -> miss again, miss_count=3.
REQ-036 flush=1 for one cycle after a line is resident, then re-fetch that address -> miss, mem_req=1.
REQ-037 Assert reset=0 mid-REFILL -> mem_req=0 in the same cycle, no instruction_valid pulse, counters=0; a subsequent fetch -> miss.
REQ-038 Drive 65536 consecutive hits -> hit_count=0x0000 and miss_count unchanged.
